// File: rtl/prgm_seq.sv
// Program sequencer: INC/JMP/BR/CALL/RET with a circular return-address stack.
// Optional sticky stack-error flag when PRGM_SEQ_STK_ERR_EN is defined.
module prgm_seq #(
    parameter int           N         = 8,
    parameter int           D         = 4,
    parameter logic [N-1:0] STEP      = N'(1),
    parameter logic [N-1:0] RESET_VEC = '0
) (
    input  logic                   clk,
    input  logic                   clear_n,
    input  logic                   stall,
    input  logic [2:0]             op,
    input  logic [N-1:0]           target,
    input  logic [N-1:0]           offset,
    output logic [N-1:0]           pc_out,
    output logic [$clog2(D+1)-1:0] sp,
    output logic                   stk_full,
    output logic                   stk_empty
`ifdef PRGM_SEQ_STK_ERR_EN
    ,
    output logic                   stk_err
`endif
);

    localparam int SPW = $clog2(D + 1);
    localparam int PW  = (D > 1) ? $clog2(D) : 1;

    localparam logic [SPW-1:0] SP_FULL  = SPW'(D);
    localparam logic [PW-1:0]  PTR_LAST = PW'(D - 1);

    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BR   = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;

    logic [N-1:0]   r_pc;
    logic [SPW-1:0] r_sp;
    logic [PW-1:0]  r_ptr;
    logic [N-1:0]   r_stk [D];

    logic [N-1:0]   w_pc_inc;
    logic [N-1:0]   w_pc_nxt;
    logic [PW-1:0]  w_ptr_inc;
    logic [PW-1:0]  w_ptr_dec;
    logic           w_full;
    logic           w_empty;
    logic           w_push;
    logic           w_pop;

    assign w_full    = (r_sp == SP_FULL);
    assign w_empty   = (r_sp == '0);
    assign w_pc_inc  = r_pc + STEP;

    // r_ptr is the next free slot; the top entry sits one below it.
    assign w_ptr_inc = (r_ptr == PTR_LAST) ? '0 : r_ptr + PW'(1);
    assign w_ptr_dec = (r_ptr == '0) ? PTR_LAST : r_ptr - PW'(1);

    always_comb begin
        w_pc_nxt = w_pc_inc;
        w_push   = 1'b0;
        w_pop    = 1'b0;
        case (op)
            OP_JMP: w_pc_nxt = target;
            OP_BR:  w_pc_nxt = r_pc + offset;
            OP_CALL: begin
                w_pc_nxt = target;
                w_push   = 1'b1;
            end
            OP_RET: begin
                if (!w_empty) begin
                    w_pc_nxt = r_stk[w_ptr_dec];
                    w_pop    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_pc  <= RESET_VEC;
            r_sp  <= '0;
            r_ptr <= '0;
        end else if (!stall) begin
            r_pc <= w_pc_nxt;
            if (w_push) begin
                r_ptr <= w_ptr_inc;
                if (!w_full)
                    r_sp <= r_sp + SPW'(1);
            end else if (w_pop) begin
                r_ptr <= w_ptr_dec;
                r_sp  <= r_sp - SPW'(1);
            end
        end
    end

    // Entry contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (clear_n && !stall && w_push)
            r_stk[r_ptr] <= w_pc_inc;
    end

`ifdef PRGM_SEQ_STK_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            r_err <= 1'b0;
        else if (!stall && ((w_push && w_full) || (op == OP_RET && w_empty)))
            r_err <= 1'b1;
    end

    assign stk_err = r_err;
`endif

    assign pc_out    = r_pc;
    assign sp        = r_sp;
    assign stk_full  = w_full;
    assign stk_empty = w_empty;

endmodule

// File: tb/tb_prgm_seq.sv
// Directed self-checking bench for prgm_seq (N=8, D=4, STEP=1, RESET_VEC=0).
// Covers the stk_err port as well when PRGM_SEQ_STK_ERR_EN is defined.
module tb_prgm_seq;

    localparam logic [2:0] INC  = 3'b000;
    localparam logic [2:0] JMP  = 3'b001;
    localparam logic [2:0] BR   = 3'b010;
    localparam logic [2:0] CALL = 3'b011;
    localparam logic [2:0] RET  = 3'b100;

    logic       clk;
    logic       clear_n;
    logic       stall;
    logic [2:0] op;
    logic [7:0] target;
    logic [7:0] offset;
    logic [7:0] pc_out;
    logic [2:0] sp;
    logic       stk_full;
    logic       stk_empty;
`ifdef PRGM_SEQ_STK_ERR_EN
    logic       stk_err;
`endif

    int checks = 0;
    int errors = 0;

    prgm_seq #(
        .N(8),
        .D(4),
        .STEP(8'd1),
        .RESET_VEC(8'h00)
    ) dut (
        .clk(clk),
        .clear_n(clear_n),
        .stall(stall),
        .op(op),
        .target(target),
        .offset(offset),
        .pc_out(pc_out),
        .sp(sp),
        .stk_full(stk_full),
        .stk_empty(stk_empty)
`ifdef PRGM_SEQ_STK_ERR_EN
        ,
        .stk_err(stk_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] o, input logic [7:0] t,
                        input logic [7:0] f, input logic s);
        op     = o;
        target = t;
        offset = f;
        stall  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [7:0] epc,
                          input logic [2:0] esp);
        chk({tag, " pc"}, 32'(pc_out), 32'(epc));
        chk({tag, " sp"}, 32'(sp), 32'(esp));
        chk({tag, " empty"}, 32'(stk_empty), 32'(esp == 3'd0));
        chk({tag, " full"}, 32'(stk_full), 32'(esp == 3'd4));
    endtask

    initial begin
        clear_n = 1'b0;
        stall   = 1'b0;
        op      = INC;
        target  = 8'h00;
        offset  = 8'h00;
        #3;
        chk_st("reset", 8'h00, 3'd0);
`ifdef PRGM_SEQ_STK_ERR_EN
        chk("reset err", 32'(stk_err), 32'd0);
`endif
        @(posedge clk);
        #1;
        clear_n = 1'b1;

        // 1: INCs then an asynchronous clear between edges
        step(INC, 8'h00, 8'h00, 1'b0);
        chk_st("inc1", 8'h01, 3'd0);
        step(INC, 8'h00, 8'h00, 1'b0);
        step(INC, 8'h00, 8'h00, 1'b0);
        chk_st("inc3", 8'h03, 3'd0);
        clear_n = 1'b0;
        #1;
        chk_st("async clr", 8'h00, 3'd0);
        #2;
        clear_n = 1'b1;

        // 2: jump near top then wrap
        step(JMP, 8'hFE, 8'h00, 1'b0);
        chk_st("jmp fe", 8'hFE, 3'd0);
        step(INC, 8'h00, 8'h00, 1'b0);
        chk_st("inc ff", 8'hFF, 3'd0);
        step(INC, 8'h00, 8'h00, 1'b0);
        chk_st("inc wrap", 8'h00, 3'd0);

        // 3: signed branches
        step(JMP, 8'h10, 8'h00, 1'b0);
        step(BR, 8'h00, 8'hFC, 1'b0);
        chk_st("br back", 8'h0C, 3'd0);
        step(JMP, 8'hFE, 8'h00, 1'b0);
        step(BR, 8'h00, 8'h04, 1'b0);
        chk_st("br wrap", 8'h02, 3'd0);

        // 4: nested call/return
        step(JMP, 8'h20, 8'h00, 1'b0);
        step(CALL, 8'h40, 8'h00, 1'b0);
        chk_st("call1", 8'h40, 3'd1);
        step(CALL, 8'h60, 8'h00, 1'b0);
        chk_st("call2", 8'h60, 3'd2);
        step(RET, 8'h00, 8'h00, 1'b0);
        chk_st("ret1", 8'h41, 3'd1);
        step(RET, 8'h00, 8'h00, 1'b0);
        chk_st("ret2", 8'h21, 3'd0);

        // 5: overflow drops the oldest entry
        step(JMP, 8'h00, 8'h00, 1'b0);
        step(CALL, 8'h10, 8'h00, 1'b0);
        step(CALL, 8'h20, 8'h00, 1'b0);
        step(CALL, 8'h30, 8'h00, 1'b0);
        step(CALL, 8'h40, 8'h00, 1'b0);
        chk_st("ovf call4", 8'h40, 3'd4);
`ifdef PRGM_SEQ_STK_ERR_EN
        chk("err before ovf", 32'(stk_err), 32'd0);
`endif
        step(CALL, 8'h50, 8'h00, 1'b0);
        chk_st("ovf call5", 8'h50, 3'd4);
`ifdef PRGM_SEQ_STK_ERR_EN
        chk("err after ovf", 32'(stk_err), 32'd1);
`endif
        step(RET, 8'h00, 8'h00, 1'b0);
        chk_st("ovf ret1", 8'h41, 3'd3);
        step(RET, 8'h00, 8'h00, 1'b0);
        chk_st("ovf ret2", 8'h31, 3'd2);
        step(RET, 8'h00, 8'h00, 1'b0);
        chk_st("ovf ret3", 8'h21, 3'd1);
        step(RET, 8'h00, 8'h00, 1'b0);
        chk_st("ovf ret4", 8'h11, 3'd0);
        step(RET, 8'h00, 8'h00, 1'b0);
        chk_st("ret empty", 8'h12, 3'd0);

        // reserved op codes act as INC
        step(3'b101, 8'hAA, 8'h55, 1'b0);
        chk_st("op101", 8'h13, 3'd0);
        step(3'b111, 8'hAA, 8'h55, 1'b0);
        chk_st("op111", 8'h14, 3'd0);

        // 6: stall holds everything, then the call proceeds
        step(JMP, 8'h05, 8'h00, 1'b0);
        step(CALL, 8'h33, 8'h00, 1'b1);
        chk_st("stall1", 8'h05, 3'd0);
        step(CALL, 8'h33, 8'h00, 1'b1);
        step(CALL, 8'h33, 8'h00, 1'b1);
        chk_st("stall3", 8'h05, 3'd0);
        step(CALL, 8'h33, 8'h00, 1'b0);
        chk_st("unstall", 8'h33, 3'd1);
        step(RET, 8'h00, 8'h00, 1'b1);
        chk_st("stall ret", 8'h33, 3'd1);
        step(RET, 8'h00, 8'h00, 1'b0);
        chk_st("ret top", 8'h06, 3'd0);

        // final clear also drops the sticky error
        clear_n = 1'b0;
        #1;
        chk_st("clr2", 8'h00, 3'd0);
`ifdef PRGM_SEQ_STK_ERR_EN
        chk("clr2 err", 32'(stk_err), 32'd0);
`endif
        #2;
        clear_n = 1'b1;
        step(INC, 8'h00, 8'h00, 1'b0);
        chk_st("post clr", 8'h01, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prgm_seq.md
Name: prgm_seq

Overview:
- Parametrised program sequencer; successor to the plain increment/load program counter.
- Adds signed relative branch, subroutine call/return with an internal return-address stack (RAS), stall, and a configurable reset vector.
- Sits in the fetch stage: pc_out drives instruction-memory address; op/target/offset come from decode.

Parameters:
N, 8, PC / address width in bits
D, 4, RAS depth in entries (>=1)
STEP, 1, PC increment per sequential advance (N-bit, unsigned)
RESET_VEC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
clear_n  in  1  asynchronous active-low reset
stall  in  1  1 = hold PC and RAS this cycle
op  in  3  000 INC, 001 JMP, 010 BR, 011 CALL, 100 RET, 101-111 treated as INC
target  in  N  absolute destination for JMP/CALL
offset  in  N  two's-complement displacement for BR
pc_out  out  N  current PC (registered)
sp  out  $clog2(D+1)  RAS occupancy, 0..D
stk_full  out  1  sp == D (combinational from sp)
stk_empty  out  1  sp == 0 (combinational from sp)

Behaviour:
- Reset: clear_n low asynchronously forces pc_out=RESET_VEC, sp=0, internal RAS pointer=0, stk_empty=1, stk_full=0. Effective regardless of clk or an operation in progress. RAS entry contents are not reset.
- All updates occur on rising clk edge while clear_n=1. Single-cycle latency: the new PC is visible the cycle after op is presented.
- Priority: clear_n > stall > op. stall=1 leaves pc_out, sp, and RAS contents unchanged, whatever op is.
- INC: pc <= pc + STEP, modulo 2^N (wraps; no flag).
- JMP: pc <= target.
- BR: pc <= pc + offset, modulo 2^N. offset is signed, relative to the current pc_out, not pc+STEP.
- CALL:
  - Push pc + STEP (mod 2^N) onto the RAS, then pc <= target.
  - If not full: sp increments.
  - If full: the push overwrites the oldest entry (circular buffer, oldest dropped). sp stays at D and the jump still occurs.
- RET:
  - If sp>0: pc <= top entry, then pop (sp decrements).
  - If sp==0: behaves as INC and sp stays 0.
- Stack implementation: circular array of D entries with an N-bit entry width. A top pointer wraps modulo D on both push and pop. Occupancy counter is separate from the pointer.
- Reserved op codes 101-111 behave exactly as INC.
- No combinational path from any input to pc_out or sp.

Optional Feature:
- Macro: PRGM_SEQ_STK_ERR_EN.
- Defined:
  - Adds output port stk_err (1 bit), reset to 0 by clear_n.
  - stk_err is set sticky on any non-stalled CALL with stk_full=1, or any non-stalled RET with stk_empty=1.
  - stk_err is cleared only by reset.
- Undefined: port and logic are absent. All other behaviour is identical.

Test Plan (N=8, D=4, STEP=1, RESET_VEC=0):
1. Run several INCs, then pulse clear_n low between clock edges -> pc_out=0x00, sp=0, stk_empty=1 immediately, before the next edge.
2. JMP target=0xFE, then INC, INC -> pc_out sequence 0xFE, 0xFF, 0x00 (wrap).
3. JMP 0x10, then BR offset=0xFC -> 0x0C. Then JMP 0xFE, BR offset=0x04 -> 0x02.
4. JMP 0x20; CALL 0x40; CALL 0x60 -> sp=2. RET -> 0x41, sp=1. RET -> 0x21, sp=0, stk_empty=1.
5. Overflow:
   - Five consecutive CALLs from PCs 0x00, 0x10, 0x20, 0x30, 0x40 -> sp=4, stk_full=1.
   - Five RETs -> return addresses 0x41, 0x31, 0x21, 0x11, then INC behaviour on the fifth; sp ends at 0.
   - With PRGM_SEQ_STK_ERR_EN: stk_err=1 from the fifth CALL onward.
6. pc=0x05, stall=1 with op=CALL target=0x33 for 3 cycles -> pc_out=0x05, sp unchanged. Then stall=0 -> pc_out=0x33, sp+1, top entry=0x06.
